fpu_share_arbiter: RTL
======================

// Module: fpu_share_arbiter
// PURPOSE
//   Shares one double-precision fpu instance among N_REQ requesters (e.g. the l_ij
//   compute machines of cholesky) so that wide matrix factorisations need not replicate
//   one fpu per element. Grants requesters in round-robin order and sequences the fpu
//   enable/ready handshake. Returns each result to its owner with a one-cycle done pulse.
//   Sits between the matrix compute machines and a single fpu.
// PARAMETERS
//   N_REQ     4    number of requesters (2..16)
//   EN_CYCLES 3    cycles fpu_enable is held high per operation (1..7)
//   TIMEOUT   255  max WAIT cycles for fpu_ready before abort (1..255, 8-bit counter)
// PORTS
//   clk           in   1         clock, all logic on posedge
//   rst           in   1         synchronous, active-high reset
//   req           in   N_REQ     level request per requester; held until its done pulse
//   op            in   N_REQ*3   fpu_op per requester (slice i at [3i+2:3i])
//   opa           in   N_REQ*64  operand A per requester (slice i at [64i+63:64i])
//   opb           in   N_REQ*64  operand B per requester
//   grant         out  N_REQ     one-hot owner of the fpu; 0 when idle
//   done          out  N_REQ     one-cycle pulse to owner: result/err valid
//   result        out  64        captured fpu_out, valid from done pulse until next done
//   err           out  1         high with done when the op timed out or fpu_invalid was set
//   busy          out  1         high in any state other than IDLE
//   fpu_enable    out  1         enable to the shared fpu
//   fpu_op        out  3         operation to the fpu (registered from owner at grant)
//   fpu_opa       out  64        operand A to the fpu (registered at grant)
//   fpu_opb       out  64        operand B to the fpu (registered at grant)
//   fpu_rmode     out  2         constant 2'b00 (round to nearest even)
//   fpu_out       in   64        fpu result
//   fpu_ready     in   1         fpu completion (level)
//   fpu_invalid   in   1         fpu invalid flag, sampled with fpu_ready
// BEHAVIOUR
//   Reset: state IDLE; grant, done, result, err, busy, fpu_enable, fpu_op, fpu_opa,
//     fpu_opb all 0; round-robin pointer = N_REQ-1 (requester 0 highest priority first).
//   rst overrides everything at any state; an in-flight op is dropped, no done issued.
//   FSM states:
//   IDLE: if any req bit set, pick first set bit scanning pointer+1, pointer+2, ...
//     (mod N_REQ); next cycle grant=onehot(g), fpu_op/opa/opb latched from slice g,
//     pointer=g, enable counter=EN_CYCLES, -> ISSUE. No req: stay.
//   ISSUE: fpu_enable=1 for exactly EN_CYCLES cycles, then -> WAIT with timeout ctr=0.
//   WAIT: fpu_enable=0. fpu_ready ignored in the first WAIT cycle (stale-ready guard).
//     From the 2nd cycle: fpu_ready=1 -> result<=fpu_out, err<=fpu_invalid, -> DONE.
//     Counter reaches TIMEOUT with no ready -> result<=0, err<=1, -> DONE.
//   DONE (1 cycle): done[g]=1, grant still one-hot g; next cycle grant=0, -> IDLE.
//   Minimum one IDLE cycle between ops; req-to-fpu_enable latency = 1 cycle.
//   Operands are captured at grant; requester may change opa/opb after grant.
//   req[g] dropped during ISSUE/WAIT: op still completes and done[g] still pulses.
//   New req bits arriving while busy wait; they are evaluated only in IDLE.
//   Owner must drop req in the cycle after done, otherwise it re-enters arbitration
//     with lowest priority (pointer just advanced past it), which guarantees fairness.
//   fpu_opa/opb/op hold last values when idle (no zeroing after an op).
// TESTING
//   Reset: hold rst 2 cycles -> all outputs 0, busy=0, fpu_rmode=2'b00.
//   req[1]=1, op=3'b010, opa=0x4000000000000000, opb=0x4008000000000000 with fpu model
//     (ready 5 cycles after enable) -> grant=4'b0010 next cycle, fpu_enable high 3 cycles,
//     done[1] pulse, result=0x4018000000000000, err=0.
//   req=4'b0101 same cycle -> requester 0 served first, then 2; done[0] before done[2].
//   req=4'b1111 held (each re-raised after done) -> grant order 0,1,2,3,0,1.
//   fpu_ready stuck 0, TIMEOUT=8 -> done pulses 8 cycles into WAIT, err=1, result=0.
//   fpu_ready held 1 from prior op -> not accepted in first WAIT cycle.
//   rst asserted mid-WAIT -> next cycle IDLE, grant=0, no done; next req serviced normally.

Source files
------------

// File: rtl/fpu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_share_arbiter
// Description : Shares one double-precision FPU among N_REQ requesters.
//               Round-robin grant, operand capture at grant, fixed-length
//               fpu_enable pulse, ready wait with stale-ready guard and
//               timeout, one-cycle done pulse back to the owner.
// Ports       : clk/rst            - clock, synchronous active-high reset
//               req/op/opa/opb     - per-requester request and operands
//               grant/done         - one-hot owner / completion pulse
//               result/err/busy    - captured result, error flag, activity
//               fpu_*              - handshake to the shared FPU
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_share_arbiter #(
    parameter int N_REQ     = 4,
    parameter int EN_CYCLES = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*3-1:0]    op,
    input  logic [N_REQ*64-1:0]   opa,
    input  logic [N_REQ*64-1:0]   opb,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      done,
    output logic [63:0]           result,
    output logic                  err,
    output logic                  busy,
    output logic                  fpu_enable,
    output logic [2:0]            fpu_op,
    output logic [63:0]           fpu_opa,
    output logic [63:0]           fpu_opb,
    output logic [1:0]            fpu_rmode,
    input  logic [63:0]           fpu_out,
    input  logic                  fpu_ready,
    input  logic                  fpu_invalid
);

    localparam int             PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W:0]   N_WIDE   = (PTR_W + 1)'(N_REQ);
    localparam logic [2:0]       EN_LOAD  = 3'(EN_CYCLES);
    localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [2:0]         en_cnt_q, en_cnt_d;
    logic [7:0]         tmo_q, tmo_d;
    logic [63:0]        result_q, result_d;
    logic               err_q, err_d;
    logic [2:0]         op_q, op_d;
    logic [63:0]        opa_q, opa_d;
    logic [63:0]        opb_q, opb_d;

    // Round-robin pick: first set req bit after ptr_q, wrapping.
    logic               req_found;
    logic [PTR_W-1:0]   pick;
    logic [PTR_W:0]     scan_sum;
    logic [PTR_W-1:0]   scan_idx;

    always_comb begin
        req_found = 1'b0;
        pick      = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (PTR_W + 1)'(k);
            if (scan_sum >= N_WIDE) begin
                scan_sum = scan_sum - N_WIDE;
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!req_found && req[scan_idx]) begin
                req_found = 1'b1;
                pick      = scan_idx;
            end
        end
    end

    // Operand mux for the picked requester (constant-index slices only).
    logic [N_REQ-1:0]   grant_sel;
    logic [2:0]         op_sel;
    logic [63:0]        opa_sel;
    logic [63:0]        opb_sel;

    always_comb begin
        grant_sel = '0;
        op_sel    = '0;
        opa_sel   = '0;
        opb_sel   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (PTR_W'(i) == pick) begin
                grant_sel[i] = 1'b1;
                op_sel       = op[i*3 +: 3];
                opa_sel      = opa[i*64 +: 64];
                opb_sel      = opb[i*64 +: 64];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        en_cnt_d = en_cnt_q;
        tmo_d    = tmo_q;
        result_d = result_q;
        err_d    = err_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        case (state_q)
            S_IDLE: begin
                if (req_found) begin
                    grant_d  = grant_sel;
                    op_d     = op_sel;
                    opa_d    = opa_sel;
                    opb_d    = opb_sel;
                    ptr_d    = pick;
                    en_cnt_d = EN_LOAD;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (en_cnt_q <= 3'd1) begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    en_cnt_d = en_cnt_q - 3'd1;
                end
            end
            S_WAIT: begin
                // tmo_q == 0 is the first WAIT cycle: a ready still high from
                // the previous operation must not be taken as this result.
                if (tmo_q != 8'd0 && fpu_ready) begin
                    result_d = fpu_out;
                    err_d    = fpu_invalid;
                    state_d  = S_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_DONE: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= PTR_RST;
            grant_q  <= '0;
            en_cnt_q <= '0;
            tmo_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            en_cnt_q <= en_cnt_d;
            tmo_q    <= tmo_d;
            result_q <= result_d;
            err_q    <= err_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
        end
    end

    assign grant      = grant_q;
    assign done       = grant_q & {N_REQ{state_q == S_DONE}};
    assign result     = result_q;
    assign err        = err_q;
    assign busy       = (state_q != S_IDLE);
    assign fpu_enable = (state_q == S_ISSUE);
    assign fpu_op     = op_q;
    assign fpu_opa    = opa_q;
    assign fpu_opb    = opb_q;
    assign fpu_rmode  = 2'b00;

endmodule
`default_nettype wire
